mb_io_arbiter: RTL
==================

Name: mb_io_arbiter

Overview:
- Two-requester arbiter that shares one Microblaze IO bus slave port between master 0 (CPU) and master 1 (debug/DMA agent).
- Captures each master's single-cycle strobe request, grants the bus round-robin, forwards one transfer at a time, and returns completion to the granted master.
- Includes a watchdog that terminates transfers when the slave never asserts IO_Ready.

Parameters:
- TIMEOUT, 256, max cycles waiting for IO_Ready before forced completion (≥2).
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on a timed-out read.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_addr_strobe  in  1  master 0 request pulse (one cycle)
- m0_read_strobe  in  1  master 0 read qualifier
- m0_write_strobe  in  1  master 0 write qualifier
- m0_address  in  32  master 0 address
- m0_byte_enable  in  4  master 0 byte enables
- m0_write_data  in  32  master 0 write data
- m0_ready  out  1  master 0 completion pulse
- m0_read_data  out  32  master 0 read data, valid with m0_ready
- m1_* (same eight signals as m0_*)  same directions/widths  master 1
- IO_Addr_Strobe  out  1  slave request pulse
- IO_Read_Strobe  out  1  slave read qualifier
- IO_Write_Strobe  out  1  slave write qualifier
- IO_Address  out  32  slave address
- IO_Byte_Enable  out  4  slave byte enables
- IO_Write_Data  out  32  slave write data
- IO_Ready  in  1  slave completion
- IO_Read_Data  in  32  slave read data
- timeout  out  1  one-cycle pulse when a transfer is terminated by the watchdog
- grant  out  1  index of the master owning the current or last transfer

Behaviour:
- Reset (async): all outputs 0; pending flags cleared; state IDLE; last-granted index = 1, so master 0 wins the first contention.
- Capture: when mN_addr_strobe is high and pending[N] = 0, register address, byte enables, write data, read/write qualifiers, and set pending[N].
  - A strobe while pending[N] = 1 is dropped; the first request is kept.
- Arbitration in IDLE:
  - One pending master: grant it.
  - Both pending: grant the one that is not the last-granted master.
  - Update grant and last-granted, then go to ISSUE.
  - A request captured in the same cycle as its strobe is visible to IDLE on the next cycle.
- ISSUE, exactly one cycle:
  - IO_Addr_Strobe = 1 with the captured qualifiers, address, byte enables, and write data.
  - Clear the watchdog counter.
  - Go to WAIT.
- WAIT:
  - IO_Addr_Strobe = 0. Address, byte enables, write data, and read/write qualifiers hold stable until completion.
  - Counter increments each cycle.
  - IO_Ready = 1: register IO_Read_Data (reads) or 0 (writes) into mN_read_data, then go to DONE.
  - Counter reaches TIMEOUT−1 without IO_Ready: set read data to TIMEOUT_DATA (reads) or 0 (writes), pulse timeout, then go to DONE.
  - IO_Ready and the timeout condition in the same cycle: IO_Ready wins and timeout stays 0.
  - IO_Ready during ISSUE is not a valid completion; the slave must respond no earlier than WAIT. If asserted during ISSUE, it is ignored.
- DONE, one cycle:
  - mN_ready = 1 for the granted master only; read data is valid this cycle.
  - Clear pending[N]; all IO_* outputs return to 0.
  - Go to IDLE.
  - mN_read_data holds its value until the next completion for that master.
- Latency, uncontended: strobe at cycle 0, IO_Addr_Strobe at cycle 2, IO_Ready at cycle k ≥ 3, mN_ready at cycle k+1.
- Back-to-back: a master may strobe again in its own DONE cycle; pending clears and recaptures in the same edge, so the new request is kept.
- Reset mid-transfer: abort immediately; no ready pulse; pending requests are lost.

Test Plan:
- Single write: m0 write to 0xC000_0010, BE=4'b1111, data 0x1234_5678; slave ready 2 cycles after strobe → IO_Address/IO_Write_Data match for the whole transfer; m0_ready one pulse; m1_ready stays 0.
- Single read: m1 read from 0xC000_0020; slave returns 0xA5A5_0F0F → m1_read_data = 0xA5A5_0F0F in the m1_ready cycle; grant = 1.
- Contention: m0 and m1 strobe in the same cycle, three times in a row → service order m0, m1, m0, m1, m0, m1; no overlapping IO_Addr_Strobe pulses.
- Timeout: TIMEOUT = 8; m0 read with IO_Ready held 0 → timeout pulse after 8 WAIT cycles; m0_read_data = 0xDEAD_BEEF with m0_ready; the next request proceeds normally.
- Dropped strobe: m0 strobes 0x10, then strobes 0x20 while the first is pending → only 0x10 reaches the slave; exactly one m0_ready.
- Reset mid-WAIT: assert reset during WAIT → all outputs 0 asynchronously; no ready pulse; after release, m0 wins contention against m1.

Source files
------------

// File: rtl/mb_io_arbiter.sv
// mb_io_arbiter
// Shares one Microblaze IO bus slave port between two masters: master 0 (CPU)
// and master 1 (debug/DMA agent). Each master's single-cycle strobe request is
// captured, the bus is granted round-robin, one transfer is forwarded at a
// time, and completion is returned to the granted master. A watchdog ends any
// transfer the slave never acknowledges.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   mN_addr_strobe/read/write      master N request pulse and qualifiers
//   mN_address/byte_enable/wdata   master N transfer payload
//   mN_ready, mN_read_data         master N completion pulse and read data
//   IO_*                           slave-side request/response
//   timeout                        pulse when the watchdog ended a transfer
//   grant                          master owning the current or last transfer
module mb_io_arbiter #(
  parameter int unsigned TIMEOUT      = 256,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_addr_strobe,
  input  logic        m0_read_strobe,
  input  logic        m0_write_strobe,
  input  logic [31:0] m0_address,
  input  logic [3:0]  m0_byte_enable,
  input  logic [31:0] m0_write_data,
  output logic        m0_ready,
  output logic [31:0] m0_read_data,
  input  logic        m1_addr_strobe,
  input  logic        m1_read_strobe,
  input  logic        m1_write_strobe,
  input  logic [31:0] m1_address,
  input  logic [3:0]  m1_byte_enable,
  input  logic [31:0] m1_write_data,
  output logic        m1_ready,
  output logic [31:0] m1_read_data,
  output logic        IO_Addr_Strobe,
  output logic        IO_Read_Strobe,
  output logic        IO_Write_Strobe,
  output logic [31:0] IO_Address,
  output logic [3:0]  IO_Byte_Enable,
  output logic [31:0] IO_Write_Data,
  input  logic        IO_Ready,
  input  logic [31:0] IO_Read_Data,
  output logic        timeout,
  output logic        grant
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CntMax = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  // Per-master request inputs gathered into arrays indexed by master number.
  logic [1:0]       w_strobe;
  logic [1:0]       w_rd;
  logic [1:0]       w_wr;
  logic [1:0][31:0] w_addr;
  logic [1:0][3:0]  w_be;
  logic [1:0][31:0] w_wdata;
  logic [1:0]       w_clr;
  logic             w_pick;

  // Captured requests.
  logic [1:0]       r_pend;
  logic [1:0]       r_rd;
  logic [1:0]       r_wr;
  logic [1:0][31:0] r_addr;
  logic [1:0][3:0]  r_be;
  logic [1:0][31:0] r_wdata;

  // FSM state and registered outputs.
  state_e           r_state;
  logic             r_grant;
  logic             r_last;
  logic [CW-1:0]    r_cnt;
  logic             r_timeout;
  logic [1:0]       r_ready;
  logic [1:0][31:0] r_rdata;
  logic             r_io_as;
  logic             r_io_rd;
  logic             r_io_wr;
  logic [31:0]      r_io_addr;
  logic [3:0]       r_io_be;
  logic [31:0]      r_io_wdata;

  assign w_strobe = {m1_addr_strobe, m0_addr_strobe};
  assign w_rd     = {m1_read_strobe, m0_read_strobe};
  assign w_wr     = {m1_write_strobe, m0_write_strobe};
  assign w_addr   = {m1_address, m0_address};
  assign w_be     = {m1_byte_enable, m0_byte_enable};
  assign w_wdata  = {m1_write_data, m0_write_data};

  // The granted master's pending flag drops at the end of its DONE cycle.
  assign w_clr[0] = (r_state == StDone) && !r_grant;
  assign w_clr[1] = (r_state == StDone) && r_grant;

  // Sole requester wins; with both pending, the one not served last wins.
  assign w_pick = (r_pend == 2'b11) ? ~r_last : ~r_pend[0];

  // Request capture. A strobe in the owner's DONE cycle is accepted because
  // the old request retires on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend  <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (w_strobe[n] && (!r_pend[n] || w_clr[n])) begin
          r_pend[n]  <= 1'b1;
          r_rd[n]    <= w_rd[n];
          r_wr[n]    <= w_wr[n];
          r_addr[n]  <= w_addr[n];
          r_be[n]    <= w_be[n];
          r_wdata[n] <= w_wdata[n];
        end else if (w_clr[n]) begin
          r_pend[n] <= 1'b0;
        end
      end
    end
  end

  // Transfer sequencer with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_grant    <= 1'b0;
      r_last     <= 1'b1;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
      r_ready    <= '0;
      r_rdata    <= '0;
      r_io_as    <= 1'b0;
      r_io_rd    <= 1'b0;
      r_io_wr    <= 1'b0;
      r_io_addr  <= '0;
      r_io_be    <= '0;
      r_io_wdata <= '0;
    end else begin
      r_timeout <= 1'b0;
      r_ready   <= '0;
      unique case (r_state)
        StIdle: begin
          if (|r_pend) begin
            r_grant    <= w_pick;
            r_last     <= w_pick;
            r_io_as    <= 1'b1;
            r_io_rd    <= r_rd[w_pick];
            r_io_wr    <= r_wr[w_pick];
            r_io_addr  <= r_addr[w_pick];
            r_io_be    <= r_be[w_pick];
            r_io_wdata <= r_wdata[w_pick];
            r_state    <= StIssue;
          end
        end
        StIssue: begin
          // IO_Ready is not sampled here; the slave may only answer in WAIT.
          r_io_as <= 1'b0;
          r_cnt   <= '0;
          r_state <= StWait;
        end
        StWait: begin
          if (IO_Ready || (r_cnt == CntMax)) begin
            // IO_Ready takes priority over a coincident watchdog expiry.
            if (IO_Ready) begin
              r_rdata[r_grant] <= r_io_rd ? IO_Read_Data : 32'h0;
            end else begin
              r_rdata[r_grant] <= r_io_rd ? TIMEOUT_DATA : 32'h0;
              r_timeout        <= 1'b1;
            end
            r_ready[r_grant] <= 1'b1;
            r_io_rd          <= 1'b0;
            r_io_wr          <= 1'b0;
            r_io_addr        <= '0;
            r_io_be          <= '0;
            r_io_wdata       <= '0;
            r_state          <= StDone;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign m0_ready        = r_ready[0];
  assign m1_ready        = r_ready[1];
  assign m0_read_data    = r_rdata[0];
  assign m1_read_data    = r_rdata[1];
  assign IO_Addr_Strobe  = r_io_as;
  assign IO_Read_Strobe  = r_io_rd;
  assign IO_Write_Strobe = r_io_wr;
  assign IO_Address      = r_io_addr;
  assign IO_Byte_Enable  = r_io_be;
  assign IO_Write_Data   = r_io_wdata;
  assign timeout         = r_timeout;
  assign grant           = r_grant;

endmodule
